cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the SRM-Starter core. It steps the instruction decoder through fetch, execute and memory-wait phases. It drives the decoder's enable and hardware-interrupt inputs, arbitrates interrupt entry against instruction fetch, and gates architectural writes to a single commit cycle per instruction. A bus watchdog traps hung memory transactions.

---
 rtl/cpu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle control sequencer for the SRM-Starter core. Steps the decoder
// through fetch, execute and memory-wait phases, arbitrates interrupt entry
// against instruction fetch at instruction boundaries, gates architectural
// writes to one commit cycle per instruction, and traps hung bus transactions.
//
// Parameters:
//   TIMEOUT  max consecutive wait cycles without mem_ack (1..2^TO_W-1)
//   TO_W     watchdog counter width
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   mem_ack      memory handshake, completes in the cycle it is high
//   hardware_int level interrupt request
//   int_en       interrupt enable (status register bit)
//   ctl_mem_req  decoder Mem_REQ line for the current instruction
//   fetch_req    instruction-fetch memory request
//   data_req     data / interrupt-vector memory request
//   ir_we        instruction register load strobe
//   dec_en       decoder enable
//   dec_hw_int   decoder hardware_int, high only during interrupt entry
//   commit       one-cycle architectural write qualifier
//   int_ack      one-cycle pulse when interrupt entry commits
//   bus_err      sticky watchdog error flag
//   state        current state encoding (debug)
module cpu_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ack,
  input  logic       hardware_int,
  input  logic       int_en,
  input  logic       ctl_mem_req,
  output logic       fetch_req,
  output logic       data_req,
  output logic       ir_we,
  output logic       dec_en,
  output logic       dec_hw_int,
  output logic       commit,
  output logic       int_ack,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MWAIT = 3'd2,
    S_ERR   = 3'd3
  } state_t;

  state_t          cur_state;
  logic            int_pending;
  logic            int_cycle;
  logic            bus_err_q;
  logic [TO_W-1:0] wdog;

  logic take_int;
  logic waiting;
  logic timeout_hit;
  logic int_done;

  // Interrupts are only recognised at an instruction boundary (S_FETCH).
  assign take_int    = (cur_state == S_FETCH) && int_pending && int_en;
  // A wait cycle is an outstanding bus request that has not been acked.
  assign waiting     = (((cur_state == S_FETCH) && !take_int) ||
                        (cur_state == S_MWAIT)) && !mem_ack;
  // mem_ack on the last tolerated cycle wins, because waiting needs !mem_ack.
  assign timeout_hit = waiting && (wdog == TO_W'(TIMEOUT - 1));
  assign int_done    = (cur_state == S_MWAIT) && mem_ack && int_cycle;

  // Outputs decode the registered state; everything is masked while rst is
  // high so a transaction interrupted by reset never commits.
  always_comb begin
    fetch_req  = 1'b0;
    data_req   = 1'b0;
    ir_we      = 1'b0;
    dec_en     = 1'b0;
    dec_hw_int = 1'b0;
    commit     = 1'b0;
    int_ack    = 1'b0;
    if (!rst) begin
      case (cur_state)
        S_FETCH: begin
          fetch_req = !take_int;
          ir_we     = !take_int && mem_ack;
        end
        S_EXEC: begin
          dec_en     = 1'b1;
          dec_hw_int = int_cycle;
          commit     = !ctl_mem_req;
        end
        S_MWAIT: begin
          dec_en     = 1'b1;
          dec_hw_int = int_cycle;
          data_req   = 1'b1;
          commit     = mem_ack;
          int_ack    = int_done;
        end
        default: ;
      endcase
    end
  end

  assign bus_err = bus_err_q && !rst;
  assign state   = cur_state;

  // Sequencer state, interrupt bookkeeping and bus watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= S_FETCH;
      int_pending <= 1'b0;
      int_cycle   <= 1'b0;
      bus_err_q   <= 1'b0;
      wdog        <= '0;
    end else begin
      // Clear beats set when both happen in the same cycle.
      int_pending <= (int_pending || hardware_int) && !int_done;
      case (cur_state)
        S_FETCH: begin
          if (take_int) begin
            cur_state <= S_EXEC;
            int_cycle <= 1'b1;
            wdog      <= '0;
          end else if (mem_ack) begin
            cur_state <= S_EXEC;
            int_cycle <= 1'b0;
            wdog      <= '0;
          end else if (timeout_hit) begin
            cur_state <= S_ERR;
            bus_err_q <= 1'b1;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_EXEC: begin
          wdog      <= '0;
          cur_state <= ctl_mem_req ? S_MWAIT : S_FETCH;
          if (!ctl_mem_req) int_cycle <= 1'b0;
        end
        S_MWAIT: begin
          if (mem_ack) begin
            cur_state <= S_FETCH;
            int_cycle <= 1'b0;
            wdog      <= '0;
          end else if (timeout_hit) begin
            cur_state <= S_ERR;
            bus_err_q <= 1'b1;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_ERR: begin
          wdog <= '0;
        end
        default: begin
          cur_state <= S_FETCH;
          int_cycle <= 1'b0;
          wdog      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Directed bench for cpu_sequencer built with TIMEOUT=4. Each step drives
// inputs just after a rising edge, compares state and all outputs
// mid-cycle against hand-computed values, then advances one clock.
// Output vector order: {fetch_req,data_req,ir_we,dec_en,dec_hw_int,commit,int_ack,bus_err}
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic       mem_ack;
  logic       hardware_int;
  logic       int_en;
  logic       ctl_mem_req;
  logic       fetch_req;
  logic       data_req;
  logic       ir_we;
  logic       dec_en;
  logic       dec_hw_int;
  logic       commit;
  logic       int_ack;
  logic       bus_err;
  logic [2:0] state;

  int checks;
  int errors;

  cpu_sequencer #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ack      (mem_ack),
    .hardware_int (hardware_int),
    .int_en       (int_en),
    .ctl_mem_req  (ctl_mem_req),
    .fetch_req    (fetch_req),
    .data_req     (data_req),
    .ir_we        (ir_we),
    .dec_en       (dec_en),
    .dec_hw_int   (dec_hw_int),
    .commit       (commit),
    .int_ack      (int_ack),
    .bus_err      (bus_err),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output patterns
  localparam logic [7:0] O_NONE   = 8'b0000_0000;
  localparam logic [7:0] O_FWAIT  = 8'b1000_0000;
  localparam logic [7:0] O_FACK   = 8'b1010_0000;
  localparam logic [7:0] O_EXEC   = 8'b0001_0000;
  localparam logic [7:0] O_EXECC  = 8'b0001_0100;
  localparam logic [7:0] O_IEXEC  = 8'b0001_1000;
  localparam logic [7:0] O_MWAIT  = 8'b0101_0000;
  localparam logic [7:0] O_MACK   = 8'b0101_0100;
  localparam logic [7:0] O_IMWAIT = 8'b0101_1000;
  localparam logic [7:0] O_IMACK  = 8'b0101_1110;
  localparam logic [7:0] O_ERR    = 8'b0000_0001;

  task automatic applyStimulus(input logic r, input logic ack, input logic hw,
                               input logic ie, input logic cm);
    rst          = r;
    mem_ack      = ack;
    hardware_int = hw;
    int_en       = ie;
    ctl_mem_req  = cm;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_state,
                             input logic [7:0] exp_out);
    logic [10:0] observed;
    logic [10:0] expected;
    observed = {state, fetch_req, data_req, ir_we, dec_en, dec_hw_int,
                commit, int_ack, bus_err};
    expected = {exp_state, exp_out};
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed state=%0d outs=%b, expected state=%0d outs=%b",
               tag, observed[10:8], observed[7:0], expected[10:8], expected[7:0]);
      end
  endtask

  task automatic step(input string tag, input logic r, input logic ack,
                      input logic hw, input logic ie, input logic cm,
                      input logic [2:0] exp_state, input logic [7:0] exp_out);
    applyStimulus(r, ack, hw, ie, cm);
    checkOutput(tag, exp_state, exp_out);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    //            tag              rst ack hw  ie  cm  state  outs
    step("reset_hold",            1, 1, 0, 0, 0, 3'd0, O_NONE);

    // ALU instructions, zero-wait memory
    step("alu0_fetch",            0, 1, 0, 0, 0, 3'd0, O_FACK);
    step("alu0_exec",             0, 1, 0, 0, 0, 3'd1, O_EXECC);
    step("alu1_fetch",            0, 1, 0, 0, 0, 3'd0, O_FACK);
    step("alu1_exec",             0, 1, 0, 0, 0, 3'd1, O_EXECC);

    // Load with three wait cycles in MWAIT
    step("ld_fetch",              0, 1, 0, 0, 1, 3'd0, O_FACK);
    step("ld_exec",               0, 0, 0, 0, 1, 3'd1, O_EXEC);
    step("ld_wait1",              0, 0, 0, 0, 1, 3'd2, O_MWAIT);
    step("ld_wait2",              0, 0, 0, 0, 1, 3'd2, O_MWAIT);
    step("ld_wait3",              0, 0, 0, 0, 1, 3'd2, O_MWAIT);
    step("ld_ack",                0, 1, 0, 0, 1, 3'd2, O_MACK);

    // Interrupt pulsed during EXEC with int_en=1
    step("irq_fetch",             0, 1, 0, 1, 0, 3'd0, O_FACK);
    step("irq_exec_pulse",        0, 1, 1, 1, 0, 3'd1, O_EXECC);
    step("irq_skip_fetch",        0, 1, 0, 1, 0, 3'd0, O_NONE);
    step("irq_entry_exec",        0, 0, 0, 1, 1, 3'd1, O_IEXEC);
    step("irq_entry_wait",        0, 0, 0, 1, 1, 3'd2, O_IMWAIT);
    step("irq_entry_ack",         0, 1, 0, 1, 1, 3'd2, O_IMACK);
    step("irq_pending_clear",     0, 1, 0, 1, 0, 3'd0, O_FACK);
    step("irq_after_exec",        0, 1, 0, 1, 0, 3'd1, O_EXECC);

    // Interrupt with int_en=0 stays pending until enabled
    step("mask_fetch",            0, 1, 0, 0, 0, 3'd0, O_FACK);
    step("mask_exec_pulse",       0, 1, 1, 0, 0, 3'd1, O_EXECC);
    step("mask_fetch_normal",     0, 1, 0, 0, 0, 3'd0, O_FACK);
    step("mask_exec",             0, 1, 0, 0, 0, 3'd1, O_EXECC);
    step("unmask_entry",          0, 1, 0, 1, 0, 3'd0, O_NONE);
    step("unmask_exec",           0, 0, 0, 1, 1, 3'd1, O_IEXEC);
    step("unmask_ack",            0, 1, 0, 1, 1, 3'd2, O_IMACK);

    // hardware_int with fetch ack in the same cycle: fetch wins
    step("race_fetch",            0, 1, 1, 1, 0, 3'd0, O_FACK);
    step("race_exec",             0, 1, 0, 1, 0, 3'd1, O_EXECC);
    step("race_entry",            0, 1, 0, 1, 0, 3'd0, O_NONE);
    step("race_int_exec",         0, 0, 0, 1, 1, 3'd1, O_IEXEC);
    // New request on the int_ack cycle: clear wins, no re-entry
    step("race_ack_setclr",       0, 1, 1, 1, 1, 3'd2, O_IMACK);
    step("setclr_fetch",          0, 1, 0, 1, 0, 3'd0, O_FACK);
    step("setclr_exec",           0, 1, 0, 1, 0, 3'd1, O_EXECC);

    // Reset in MWAIT with mem_ack on the same edge
    step("rstmw_fetch",           0, 1, 0, 0, 1, 3'd0, O_FACK);
    step("rstmw_exec",            0, 0, 0, 0, 1, 3'd1, O_EXEC);
    step("rstmw_nocommit",        1, 1, 0, 0, 1, 3'd2, O_NONE);
    step("rstmw_cleared",         1, 0, 0, 0, 0, 3'd0, O_NONE);

    // Fetch watchdog expires after four unacked wait cycles
    step("wd_wait1",              0, 0, 0, 0, 0, 3'd0, O_FWAIT);
    step("wd_wait2",              0, 0, 0, 0, 0, 3'd0, O_FWAIT);
    step("wd_wait3",              0, 0, 0, 0, 0, 3'd0, O_FWAIT);
    step("wd_wait4",              0, 0, 0, 0, 0, 3'd0, O_FWAIT);
    step("wd_err",                0, 1, 0, 0, 0, 3'd3, O_ERR);
    step("wd_err_hold",           0, 1, 0, 1, 1, 3'd3, O_ERR);
    step("wd_err_rst",            1, 0, 0, 0, 0, 3'd3, O_NONE);

    // Ack arriving on the fourth wait cycle completes normally
    step("wd2_wait1",             0, 0, 0, 0, 0, 3'd0, O_FWAIT);
    step("wd2_wait2",             0, 0, 0, 0, 0, 3'd0, O_FWAIT);
    step("wd2_wait3",             0, 0, 0, 0, 0, 3'd0, O_FWAIT);
    step("wd2_ack4",              0, 1, 0, 0, 0, 3'd0, O_FACK);
    step("wd2_exec",              0, 1, 0, 0, 0, 3'd1, O_EXECC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
